// File: rtl/apb32_to_axi64_lite.sv
// APB slave (32-bit) that turns each access into one AXI4-Lite transfer on a 64-bit bus.
// Only one AXI transaction is ever in flight; the APB side waits in PREADY=0 until it returns.
module apb32_to_axi64_lite #(
  parameter int unsigned              AxiAddrWidth = 64,
  parameter logic [AxiAddrWidth-1:0] AddrBase     = '0
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  // APB slave
  input  logic                    psel_i,
  input  logic                    penable_i,
  input  logic                    pwrite_i,
  input  logic [31:0]             paddr_i,
  input  logic [31:0]             pwdata_i,
  output logic [31:0]             prdata_o,
  output logic                    pready_o,
  output logic                    pslverr_o,
  // AXI-Lite write address / data / response
  output logic                    aw_valid_o,
  input  logic                    aw_ready_i,
  output logic [AxiAddrWidth-1:0] aw_addr_o,
  output logic                    w_valid_o,
  input  logic                    w_ready_i,
  output logic [63:0]             w_data_o,
  output logic [7:0]              w_strb_o,
  input  logic                    b_valid_i,
  output logic                    b_ready_o,
  input  logic [1:0]              b_resp_i,
  // AXI-Lite read address / data
  output logic                    ar_valid_o,
  input  logic                    ar_ready_i,
  output logic [AxiAddrWidth-1:0] ar_addr_o,
  input  logic                    r_valid_i,
  output logic                    r_ready_o,
  input  logic [63:0]             r_data_i,
  input  logic [1:0]              r_resp_i
);

  typedef enum logic [2:0] {
    IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, DONE
  } state_e;

  state_e                  state_q, state_d;
  logic [31:2]             addr_q;
  logic [31:0]             wdata_q;
  logic [31:0]             prdata_q;
  logic                    aw_done_q, w_done_q;
  logic                    err_q;
  logic [AxiAddrWidth-1:0] axi_addr;
  logic                    apb_access;
  logic                    misaligned;

  // Only bit 1 of the AXI response (SLVERR/DECERR) maps onto PSLVERR.
  logic unused_resp_bits;
  assign unused_resp_bits = ^{b_resp_i[0], r_resp_i[0]};

  assign apb_access = psel_i && penable_i;
  assign misaligned = (paddr_i[1:0] != 2'b00);

  // Word-aligned APB address, zero-extended (or truncated) to the AXI width, then rebased.
  assign axi_addr  = AddrBase + AxiAddrWidth'({addr_q, 2'b00});
  assign aw_addr_o = axi_addr;
  assign ar_addr_o = axi_addr;
  assign w_data_o  = {wdata_q, wdata_q};
  assign w_strb_o  = addr_q[2] ? 8'hF0 : 8'h0F;
  assign prdata_o  = prdata_q;

  always_comb begin
    // NOTE: every output of this block is given a default first, so no branch can infer a latch.
    state_d    = state_q;
    aw_valid_o = 1'b0;
    w_valid_o  = 1'b0;
    ar_valid_o = 1'b0;
    b_ready_o  = 1'b0;
    r_ready_o  = 1'b0;
    pready_o   = 1'b0;
    pslverr_o  = 1'b0;
    case (state_q)
      IDLE: begin
        if (apb_access) begin
          if (misaligned)    state_d = DONE;
          else if (pwrite_i) state_d = WR_REQ;
          else               state_d = RD_REQ;
        end
      end
      WR_REQ: begin
        // AW and W complete independently; leave once both have, even in the same cycle.
        aw_valid_o = !aw_done_q;
        w_valid_o  = !w_done_q;
        if ((aw_done_q || aw_ready_i) && (w_done_q || w_ready_i)) state_d = WR_RESP;
      end
      WR_RESP: begin
        b_ready_o = 1'b1;
        if (b_valid_i) state_d = DONE;
      end
      RD_REQ: begin
        ar_valid_o = 1'b1;
        if (ar_ready_i) state_d = RD_RESP;
      end
      RD_RESP: begin
        r_ready_o = 1'b1;
        if (r_valid_i) state_d = DONE;
      end
      DONE: begin
        pready_o  = 1'b1;
        pslverr_o = err_q;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
    if (rst_i) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      prdata_q  <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (apb_access) begin
            addr_q    <= paddr_i[31:2];
            wdata_q   <= pwdata_i;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            err_q     <= misaligned;
            if (misaligned) prdata_q <= '0;
          end
        end
        WR_REQ: begin
          if (!aw_done_q && aw_ready_i) aw_done_q <= 1'b1;
          if (!w_done_q && w_ready_i)   w_done_q  <= 1'b1;
        end
        WR_RESP: begin
          if (b_valid_i) begin
            err_q    <= b_resp_i[1];
            prdata_q <= '0;
          end
        end
        RD_RESP: begin
          if (r_valid_i) begin
            err_q    <= r_resp_i[1];
            prdata_q <= addr_q[2] ? r_data_i[63:32] : r_data_i[31:0];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_apb32_to_axi64_lite.sv
// Bench for apb32_to_axi64_lite: APB master stimulus, configurable AXI-Lite slave,
// and a negedge monitor that pops expectations from scoreboard queues.
module tb_apb32_to_axi64_lite;

  localparam int unsigned AW   = 64;
  localparam logic [63:0] BASE = 64'h0000_0000_8000_0000;

  logic          clk, rst_i;
  logic          psel_i, penable_i, pwrite_i;
  logic [31:0]   paddr_i, pwdata_i, prdata_o;
  logic          pready_o, pslverr_o;
  logic          aw_valid_o, aw_ready_i;
  logic [AW-1:0] aw_addr_o;
  logic          w_valid_o, w_ready_i;
  logic [63:0]   w_data_o;
  logic [7:0]    w_strb_o;
  logic          b_valid_i, b_ready_o;
  logic [1:0]    b_resp_i;
  logic          ar_valid_o, ar_ready_i;
  logic [AW-1:0] ar_addr_o;
  logic          r_valid_i, r_ready_o;
  logic [63:0]   r_data_i;
  logic [1:0]    r_resp_i;

  apb32_to_axi64_lite #(.AxiAddrWidth(AW), .AddrBase(BASE)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .psel_i(psel_i), .penable_i(penable_i), .pwrite_i(pwrite_i),
    .paddr_i(paddr_i), .pwdata_i(pwdata_i),
    .prdata_o(prdata_o), .pready_o(pready_o), .pslverr_o(pslverr_o),
    .aw_valid_o(aw_valid_o), .aw_ready_i(aw_ready_i), .aw_addr_o(aw_addr_o),
    .w_valid_o(w_valid_o), .w_ready_i(w_ready_i), .w_data_o(w_data_o), .w_strb_o(w_strb_o),
    .b_valid_i(b_valid_i), .b_ready_o(b_ready_o), .b_resp_i(b_resp_i),
    .ar_valid_o(ar_valid_o), .ar_ready_i(ar_ready_i), .ar_addr_o(ar_addr_o),
    .r_valid_i(r_valid_i), .r_ready_o(r_ready_o), .r_data_i(r_data_i), .r_resp_i(r_resp_i)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  always @(posedge clk) cyc++;

  // ---------------- scoreboard ----------------
  typedef struct {
    logic [31:0] prdata;
    logic        err;
    int          lat;   // -1 when the slave inserts waits
    int          acc;
  } apb_exp_t;

  apb_exp_t    exp_apb[$];
  logic [63:0] exp_aw[$], exp_ar[$], exp_w[$];
  logic [7:0]  exp_strb[$];
  int          exp_b = 0, exp_r = 0;

  int n_checks = 0, n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
    n_checks++;
    if (act !== want) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, want, $time);
    end
  endtask

  // ---------------- AXI slave configuration ----------------
  int          cfg_aw_dly, cfg_w_dly, cfg_ar_dly, cfg_b_dly, cfg_r_dly;
  logic [1:0]  cfg_bresp, cfg_rresp;
  logic [63:0] cfg_rdata;

  task automatic set_slave(input int awd, input int wd, input int ard, input int bd, input int rd,
                           input logic [1:0] br, input logic [1:0] rr, input logic [63:0] rdata);
    cfg_aw_dly = awd; cfg_w_dly = wd; cfg_ar_dly = ard; cfg_b_dly = bd; cfg_r_dly = rd;
    cfg_bresp = br; cfg_rresp = rr; cfg_rdata = rdata;
  endtask

  // ---------------- slave + monitor (negedge) ----------------
  int          aw_wait, w_wait, ar_wait, b_wait, r_wait;
  bit          aw_got, w_got, ar_got;
  bit          aw_pend, w_pend, ar_pend;
  logic [63:0] aw_prev, w_prev, ar_prev;
  int          aw_vcnt, w_vcnt, ar_vcnt, b_cnt, r_cnt;
  logic [31:0] last_prdata;
  apb_exp_t    mon_e;

  initial begin
    aw_ready_i = 1'b0; w_ready_i = 1'b0; ar_ready_i = 1'b0;
    b_valid_i = 1'b0; r_valid_i = 1'b0; b_resp_i = 2'b00; r_resp_i = 2'b00; r_data_i = '0;
    aw_wait = 0; w_wait = 0; ar_wait = 0; b_wait = 0; r_wait = 0;
    aw_got = 0; w_got = 0; ar_got = 0; aw_pend = 0; w_pend = 0; ar_pend = 0;
    aw_prev = '0; w_prev = '0; ar_prev = '0;
    aw_vcnt = 0; w_vcnt = 0; ar_vcnt = 0; b_cnt = 0; r_cnt = 0;
    last_prdata = '0;
  end

  always @(negedge clk) begin
    if (rst_i) begin
      // slave is reset together with the bridge
      aw_ready_i = 1'b0; w_ready_i = 1'b0; ar_ready_i = 1'b0; b_valid_i = 1'b0; r_valid_i = 1'b0;
      aw_wait = 0; w_wait = 0; ar_wait = 0; b_wait = 0; r_wait = 0;
      aw_got = 0; w_got = 0; ar_got = 0; aw_pend = 0; w_pend = 0; ar_pend = 0;
    end else begin
      // slave: each ready rises after its configured number of waiting cycles
      if (aw_valid_o && aw_wait >= cfg_aw_dly) aw_ready_i = 1'b1;
      else begin aw_ready_i = 1'b0; if (aw_valid_o) aw_wait++; end
      if (w_valid_o && w_wait >= cfg_w_dly) w_ready_i = 1'b1;
      else begin w_ready_i = 1'b0; if (w_valid_o) w_wait++; end
      if (ar_valid_o && ar_wait >= cfg_ar_dly) ar_ready_i = 1'b1;
      else begin ar_ready_i = 1'b0; if (ar_valid_o) ar_wait++; end
      if (aw_got && w_got && b_wait >= cfg_b_dly) begin b_valid_i = 1'b1; b_resp_i = cfg_bresp; end
      else begin b_valid_i = 1'b0; if (aw_got && w_got) b_wait++; end
      if (ar_got && r_wait >= cfg_r_dly) begin
        r_valid_i = 1'b1; r_resp_i = cfg_rresp; r_data_i = cfg_rdata;
      end else begin
        r_valid_i = 1'b0; r_data_i = ~cfg_rdata; if (ar_got) r_wait++;
      end

      // a valid left waiting last cycle must still be up with the same payload
      if (aw_pend) begin check("aw_valid_held", aw_valid_o, 1); check("aw_addr_stable", aw_addr_o, aw_prev); end
      if (w_pend)  begin check("w_valid_held", w_valid_o, 1);   check("w_data_stable", w_data_o, w_prev); end
      if (ar_pend) begin check("ar_valid_held", ar_valid_o, 1); check("ar_addr_stable", ar_addr_o, ar_prev); end
      aw_pend = aw_valid_o && !aw_ready_i; aw_prev = aw_addr_o;
      w_pend  = w_valid_o && !w_ready_i;   w_prev  = w_data_o;
      ar_pend = ar_valid_o && !ar_ready_i; ar_prev = ar_addr_o;
      aw_vcnt += int'(aw_valid_o); w_vcnt += int'(w_valid_o); ar_vcnt += int'(ar_valid_o);

      // handshakes completing at the coming rising edge
      if (aw_valid_o && aw_ready_i) begin
        aw_got = 1; aw_wait = 0;
        check("aw_expected", exp_aw.size() > 0, 1);
        if (exp_aw.size() > 0) check("aw_addr", aw_addr_o, exp_aw.pop_front());
      end
      if (w_valid_o && w_ready_i) begin
        w_got = 1; w_wait = 0;
        check("w_expected", exp_w.size() > 0, 1);
        if (exp_w.size() > 0) begin
          check("w_data", w_data_o, exp_w.pop_front());
          check("w_strb", w_strb_o, exp_strb.pop_front());
        end
      end
      if (ar_valid_o && ar_ready_i) begin
        ar_got = 1; ar_wait = 0;
        check("ar_expected", exp_ar.size() > 0, 1);
        if (exp_ar.size() > 0) check("ar_addr", ar_addr_o, exp_ar.pop_front());
      end
      if (b_valid_i && b_ready_o) begin b_cnt++; aw_got = 0; w_got = 0; b_wait = 0; end
      if (r_valid_i && r_ready_o) begin r_cnt++; ar_got = 0; r_wait = 0; end

      // APB completion
      if (pready_o) begin
        check("apb_expected", exp_apb.size() > 0, 1);
        if (exp_apb.size() > 0) begin
          mon_e = exp_apb.pop_front();
          check("prdata", prdata_o, mon_e.prdata);
          check("pslverr", pslverr_o, mon_e.err);
          if (mon_e.lat >= 0) check("latency", cyc - mon_e.acc + 1, mon_e.lat);
          last_prdata = mon_e.prdata;
        end
      end else begin
        check("pslverr_idle", pslverr_o, 0);
        check("prdata_hold", prdata_o, last_prdata);
      end
    end
  end

  // ---------------- APB master + reference model ----------------
  task automatic apb_start(input bit wr, input logic [31:0] addr, input logic [31:0] data);
    apb_exp_t    e;
    logic [63:0] axi_addr;
    bit          mis, upper, fast;
    mis      = (addr % 4) != 0;
    upper    = ((addr / 4) % 2) == 1;
    axi_addr = BASE + 64'(addr - addr % 4);
    fast     = (cfg_aw_dly == 0 && cfg_w_dly == 0 && cfg_ar_dly == 0 && cfg_b_dly == 0 && cfg_r_dly == 0);
    @(posedge clk); #1;
    psel_i = 1'b1; penable_i = 1'b0; pwrite_i = wr; paddr_i = addr; pwdata_i = data;
    @(posedge clk); #1;
    penable_i = 1'b1;
    e.acc = cyc;
    if (mis) begin
      e.prdata = '0; e.err = 1'b1; e.lat = 2;
    end else if (wr) begin
      exp_aw.push_back(axi_addr);
      exp_w.push_back({data, data});
      exp_strb.push_back(upper ? 8'hF0 : 8'h0F);
      e.prdata = '0; e.err = (cfg_bresp >= 2); e.lat = fast ? 4 : -1;
      exp_b++;
    end else begin
      exp_ar.push_back(axi_addr);
      e.prdata = upper ? 32'(cfg_rdata >> 32) : 32'(cfg_rdata);
      e.err = (cfg_rresp >= 2); e.lat = fast ? 4 : -1;
      exp_r++;
    end
    exp_apb.push_back(e);
  endtask

  task automatic apb_wait();
    int budget;
    bit done;
    budget = 300; done = 0;
    while (!done && budget > 0) begin
      @(negedge clk);
      if (pready_o) done = 1;
      budget--;
    end
    check("pready_seen", done, 1);
    @(posedge clk); #1;
    psel_i = 1'b0; penable_i = 1'b0;
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_pready"}, pready_o, 0);
    check({tag, "_pslverr"}, pslverr_o, 0);
    check({tag, "_prdata"}, prdata_o, 0);
    check({tag, "_valids"}, {aw_valid_o, w_valid_o, ar_valid_o}, 0);
    check({tag, "_readies"}, {b_ready_o, r_ready_o}, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  bit          r_wr;
  logic [31:0] r_addr;
  int          b0;

  initial begin
    rst_i = 1'b1; psel_i = 1'b0; penable_i = 1'b0; pwrite_i = 1'b0; paddr_i = '0; pwdata_i = '0;
    set_slave(0, 0, 0, 0, 0, 2'b00, 2'b00, 64'h0);
    repeat (3) @(posedge clk);
    #1 rst_i = 1'b0;
    @(negedge clk);
    check_quiet("reset");

    // fast write to upper word
    set_slave(0, 0, 0, 0, 0, 2'b00, 2'b00, 64'h0);
    apb_start(1'b1, 32'h0000_1004, 32'hDEAD_BEEF);
    apb_wait();

    // fast read of lower word
    set_slave(0, 0, 0, 0, 0, 2'b00, 2'b00, 64'h1111_2222_3333_4444);
    apb_start(1'b0, 32'h0000_0000, 32'h0);
    apb_wait();

    // read of upper word
    set_slave(0, 0, 0, 0, 0, 2'b00, 2'b01, 64'hAAAA_5555_1234_5678);
    apb_start(1'b0, 32'h0000_0104, 32'h0);
    apb_wait();

    // W accepted five cycles after AW
    set_slave(0, 5, 0, 0, 0, 2'b00, 2'b00, 64'h0);
    aw_vcnt = 0; w_vcnt = 0; b0 = b_cnt;
    apb_start(1'b1, 32'h0000_2000, 32'h0BAD_F00D);
    apb_wait();
    check("aw_valid_cycles", aw_vcnt, 1);
    check("w_valid_cycles", w_vcnt, 6);
    check("single_b", b_cnt - b0, 1);

    // read returning SLVERR
    set_slave(0, 0, 0, 0, 0, 2'b00, 2'b10, 64'hCAFE_0000_FACE_0001);
    apb_start(1'b0, 32'h0000_0008, 32'h0);
    apb_wait();

    // misaligned: no AXI activity, error after two cycles
    aw_vcnt = 0; w_vcnt = 0; ar_vcnt = 0;
    apb_start(1'b0, 32'h0000_0002, 32'h0);
    apb_wait();
    check("misaligned_no_axi", aw_vcnt + w_vcnt + ar_vcnt, 0);

    // reset while waiting for B
    set_slave(0, 0, 0, 100, 0, 2'b00, 2'b00, 64'h0);
    apb_start(1'b1, 32'h0000_3000, 32'h1234_5678);
    begin
      int budget;
      budget = 50;
      while (!b_ready_o && budget > 0) begin @(negedge clk); budget--; end
    end
    check("reached_wr_resp", b_ready_o, 1);
    @(posedge clk); #1;
    rst_i = 1'b1; psel_i = 1'b0; penable_i = 1'b0;
    exp_apb.delete(); exp_b--;
    @(posedge clk); #1;
    rst_i = 1'b0; last_prdata = '0;
    @(negedge clk);
    check_quiet("mid_reset");
    set_slave(0, 0, 0, 0, 0, 2'b00, 2'b00, 64'h7777_6666_5555_4444);
    apb_start(1'b0, 32'h0000_0010, 32'h0);
    apb_wait();

    // randomized traffic
    for (int i = 0; i < 40; i++) begin
      r_wr   = 1'($urandom_range(0, 1));
      r_addr = $urandom;
      if ($urandom_range(0, 5) != 0) r_addr[1:0] = 2'b00;
      if ($urandom_range(0, 3) == 0)
        set_slave(0, 0, 0, 0, 0, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), {$urandom, $urandom});
      else
        set_slave($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                  $urandom_range(0, 3), $urandom_range(0, 3),
                  2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), {$urandom, $urandom});
      apb_start(r_wr, r_addr, $urandom);
      apb_wait();
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end

    repeat (3) @(posedge clk);
    check("apb_queue_empty", exp_apb.size(), 0);
    check("aw_queue_empty", exp_aw.size(), 0);
    check("w_queue_empty", exp_w.size(), 0);
    check("ar_queue_empty", exp_ar.size(), 0);
    check("b_count", b_cnt, exp_b);
    check("r_count", r_cnt, exp_r);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/apb32_to_axi64_lite.md
APB32_TO_AXI64_LITE -- requirements
Module: apb32_to_axi64_lite

Interface
REQ-001 SHALL have parameter AxiAddrWidth, default 64: width of aw_addr_o/ar_addr_o.
REQ-002 SHALL have parameter AddrBase, default 0 (AxiAddrWidth bits): offset added to the zero-extended paddr_i.
REQ-003 SHALL have one clock and a synchronous active-high reset (ports below).
REQ-004 clk_i  in  1  clock, all logic rising-edge.
REQ-005 rst_i  in  1  synchronous reset, active-high.
REQ-006 psel_i / penable_i / pwrite_i  in  1 each  APB slave select, enable, write.
REQ-007 paddr_i  in  32  APB byte address; pwdata_i  in  32  APB write data.
REQ-008 prdata_o  out  32  read data; pready_o  out  1  transfer done; pslverr_o  out  1  error.
REQ-009 aw_valid_o out 1, aw_ready_i in 1, aw_addr_o out AxiAddrWidth: AXI-Lite write address.
REQ-010 w_valid_o out 1, w_ready_i in 1, w_data_o out 64, w_strb_o out 8: AXI-Lite write data.
REQ-011 b_valid_i in 1, b_ready_o out 1, b_resp_i in 2: AXI-Lite write response.
REQ-012 ar_valid_o out 1, ar_ready_i in 1, ar_addr_o out AxiAddrWidth: AXI-Lite read address.
REQ-013 r_valid_i in 1, r_ready_o out 1, r_data_i in 64, r_resp_i in 2: AXI-Lite read data.

Function
REQ-014 SHALL implement FSM states IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, DONE.
REQ-015 IDLE: on psel_i&&penable_i, SHALL latch paddr_i, pwdata_i, pwrite_i; go to WR_REQ if pwrite_i else RD_REQ.
REQ-016 IDLE with paddr_i[1:0]!=0: SHALL issue no AXI transfer, set error flag, go to DONE.
REQ-017 Address out SHALL be AddrBase + {paddr[31:2],2'b00} zero-extended, modulo 2^AxiAddrWidth.
REQ-018 WR_REQ: aw_valid_o and w_valid_o SHALL rise together the cycle after latching; each SHALL drop the cycle after its own handshake, independently.
REQ-019 w_data_o SHALL be {pwdata,pwdata}; w_strb_o SHALL be 8'hF0 if paddr[2] else 8'h0F.
REQ-020 Leave WR_REQ for WR_RESP once both AW and W have handshaken, including both in the same cycle.
REQ-021 WR_RESP: b_ready_o=1; on b_valid_i, capture b_resp_i[1] as error flag, go to DONE.
REQ-022 RD_REQ: ar_valid_o=1 until ar_ready_i, then RD_RESP.
REQ-023 RD_RESP: r_ready_o=1; on r_valid_i, register prdata_o = paddr[2] ? r_data_i[63:32] : r_data_i[31:0]; error flag = r_resp_i[1]; go to DONE.
REQ-024 DONE: pready_o=1 and pslverr_o=error flag for exactly one cycle, then IDLE; no new transfer accepted in DONE.
REQ-025 pready_o SHALL be 0 in every state except DONE; pslverr_o SHALL be 0 when pready_o=0.
REQ-026 prdata_o SHALL hold its last value outside DONE; for writes and misaligned accesses it SHALL be 0 in DONE.
REQ-027 Valid outputs SHALL not depend combinationally on any ready input; AXI valids SHALL never drop before handshake.
REQ-028 Minimum latency (all readies and responses high immediately): 4 cycles from the APB access-phase edge to pready_o.
REQ-029 At most one outstanding AXI transaction; the B or R channel ready SHALL be 0 outside its RESP state.

Reset
REQ-030 rst_i high at a clock edge SHALL force IDLE and set every valid/ready/pready_o/pslverr_o to 0, prdata_o to 0, error flag to 0, from the following cycle.
REQ-031 Reset mid-transaction SHALL abandon the transfer without completing it; the bench SHALL treat the AXI slave as reset concurrently.

Verification
REQ-032 Write paddr=0x0000_1004, pwdata=0xDEADBEEF, AddrBase=0x8000_0000, readies high, b_resp=0 -> aw_addr_o=0x8000_1004, w_strb_o=0xF0, w_data_o=0xDEADBEEF_DEADBEEF, pready_o 1 cycle, pslverr_o=0.
REQ-033 Read paddr=0x0000_0000, r_data_i=0x1111_2222_3333_4444, r_resp=0 -> prdata_o=0x3333_4444, pready_o after 4 cycles, pslverr_o=0.
REQ-034 Write with w_ready_i delayed 5 cycles after aw_ready_i -> aw_valid_o drops after AW handshake, w_valid_o held stable 5 cycles, single B accepted.
REQ-035 Read with r_resp_i=2'b10 -> pslverr_o=1 coincident with pready_o.
REQ-036 Access paddr=0x0000_0002 -> no AXI valid asserted, pready_o=1 and pslverr_o=1 two cycles after access phase.
REQ-037 rst_i asserted while in WR_RESP -> next cycle all outputs 0, FSM IDLE; subsequent read completes normally.
